// File: rtl/lm_sm_sequencer.sv
// rtl/lm_sm_sequencer.sv - LM/SM multiple-register load/store sequencer
//
// Purpose: walks an 8-bit register mask from R0 upward, issuing one memory
// access per set bit at consecutive addresses. Loads also write the register
// file through a one-cycle WB state. Owns the memory/RF ports while busy.
//
// Optional feature macro: LMSM_BASE_WRITEBACK_EN (adds base_we/base_next).
//
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   start               one-cycle request, honoured only in IDLE
//   is_store            1 = SM (RF->mem), 0 = LM (mem->RF), sampled with start
//   reg_mask            registers to transfer, sampled with start
//   base_addr           first memory address, sampled with start
//   mem_ack, mem_rdata  memory completion and read data
//   busy, done          ownership flag and one-cycle completion pulse
//   mem_en, read_wbar   memory request (held until ack) and direction
//   mem_addr            current access address
//   rf_addr, rf_we      RF index (read port for SM, write port for LM), write strobe
//   rf_wdata            latched load data
//   base_we, base_next  (macro only) base register update in DONE
module lm_sm_sequencer #(
  parameter int NREGS  = 8,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int RIDX_W = 3
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              is_store,
  input  logic [NREGS-1:0]  reg_mask,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              done,
  output logic              mem_en,
  output logic              read_wbar,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [RIDX_W-1:0] rf_addr,
  output logic              rf_we,
  output logic [DATA_W-1:0] rf_wdata
`ifdef LMSM_BASE_WRITEBACK_EN
  ,
  output logic              base_we,
  output logic [ADDR_W-1:0] base_next
`endif
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_WB     = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t            state_q, state_d;
  logic [NREGS-1:0]  rem_mask_q, rem_mask_d;
  logic [ADDR_W-1:0] cur_addr_q, cur_addr_d;
  logic              dir_q, dir_d;
  logic [RIDX_W-1:0] rf_idx_q, rf_idx_d;
  logic [DATA_W-1:0] rf_wdata_q, rf_wdata_d;
  logic [RIDX_W-1:0] lo_idx;

  // Priority encoder: scanning downward lets the lowest set bit win.
  always_comb begin
    lo_idx = '0;
    for (int i = NREGS - 1; i >= 0; i--) begin
      if (rem_mask_q[i]) lo_idx = RIDX_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    rem_mask_d = rem_mask_q;
    cur_addr_d = cur_addr_q;
    dir_d      = dir_q;
    rf_idx_d   = rf_idx_q;
    rf_wdata_d = rf_wdata_q;
    busy       = 1'b0;
    done       = 1'b0;
    mem_en     = 1'b0;
    read_wbar  = 1'b1;
    mem_addr   = '0;
    rf_addr    = '0;
    rf_we      = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          rem_mask_d = reg_mask;
          cur_addr_d = base_addr;
          dir_d      = is_store;
          state_d    = (reg_mask != '0) ? S_ACCESS : S_DONE;
        end
      end
      S_ACCESS: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_addr  = cur_addr_q;
        read_wbar = ~dir_q;
        rf_addr   = lo_idx;
        if (mem_ack) begin
          rem_mask_d = rem_mask_q & ~(NREGS'(1) << lo_idx);
          cur_addr_d = cur_addr_q + ADDR_W'(1);
          if (!dir_q) begin
            rf_wdata_d = mem_rdata;
            rf_idx_d   = lo_idx;
            state_d    = S_WB;
          end else begin
            state_d = (rem_mask_d != '0) ? S_ACCESS : S_DONE;
          end
        end
      end
      S_WB: begin
        busy    = 1'b1;
        rf_we   = 1'b1;
        rf_addr = rf_idx_q;
        state_d = (rem_mask_q != '0) ? S_ACCESS : S_DONE;
      end
      S_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_IDLE;
      rem_mask_q <= '0;
      cur_addr_q <= '0;
      dir_q      <= 1'b0;
      rf_idx_q   <= '0;
      rf_wdata_q <= '0;
    end else begin
      state_q    <= state_d;
      rem_mask_q <= rem_mask_d;
      cur_addr_q <= cur_addr_d;
      dir_q      <= dir_d;
      rf_idx_q   <= rf_idx_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  assign rf_wdata = rf_wdata_q;

`ifdef LMSM_BASE_WRITEBACK_EN
  // cur_addr advanced once per set bit, so in DONE it already equals
  // base_addr + popcount(reg_mask) modulo 2^ADDR_W; no separate popcount.
  assign base_we   = (state_q == S_DONE);
  assign base_next = base_we ? cur_addr_q : '0;
`endif

endmodule

// File: tb/tb_lm_sm_sequencer.sv
// tb/tb_lm_sm_sequencer.sv - directed self-checking bench for lm_sm_sequencer
module tb_lm_sm_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_store;
  logic [7:0]  reg_mask;
  logic [15:0] base_addr;
  logic        mem_ack;
  logic [15:0] mem_rdata;
  logic        busy, done, mem_en, read_wbar, rf_we;
  logic [15:0] mem_addr, rf_wdata;
  logic [2:0]  rf_addr;
`ifdef LMSM_BASE_WRITEBACK_EN
  logic        base_we;
  logic [15:0] base_next;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lm_sm_sequencer dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .is_store  (is_store),
    .reg_mask  (reg_mask),
    .base_addr (base_addr),
    .mem_ack   (mem_ack),
    .mem_rdata (mem_rdata),
    .busy      (busy),
    .done      (done),
    .mem_en    (mem_en),
    .read_wbar (read_wbar),
    .mem_addr  (mem_addr),
    .rf_addr   (rf_addr),
    .rf_we     (rf_we),
    .rf_wdata  (rf_wdata)
`ifdef LMSM_BASE_WRITEBACK_EN
    ,
    .base_we   (base_we),
    .base_next (base_next)
`endif
  );

  // Pulses start for one cycle; returns at the negedge of cycle 1 (first
  // cycle after the edge that samples start).
  task automatic issue_start(input logic st, input logic [7:0] m, input logic [15:0] b);
    @(negedge clk);
    start = 1'b1; is_store = st; reg_mask = m; base_addr = b;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if ({busy, done, mem_en, rf_we, read_wbar} !== 5'b00001) begin
      errors++; $display("FAIL reset_ctrl got %b exp 00001", {busy, done, mem_en, rf_we, read_wbar});
    end
    checks++;
    if ({mem_addr, rf_addr, rf_wdata} !== 35'h0) begin
      errors++; $display("FAIL reset_data got %h exp 0", {mem_addr, rf_addr, rf_wdata});
    end
    reset = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy got %b exp 0", busy); end
  endtask

  task automatic test_lm_basic();
    logic        e_en [6] = '{1, 0, 1, 0, 0, 0};
    logic        e_we [6] = '{0, 1, 0, 1, 0, 0};
    logic        e_dn [6] = '{0, 0, 0, 0, 1, 0};
    logic        e_bs [6] = '{1, 1, 1, 1, 1, 0};
    logic [15:0] e_ad [6] = '{16'h0010, 16'h0, 16'h0011, 16'h0, 16'h0, 16'h0};
    logic [2:0]  e_ra [6] = '{3'd0, 3'd0, 3'd2, 3'd2, 3'd0, 3'd0};
    logic [15:0] e_wd [6] = '{16'h0, 16'hAAAA, 16'h0, 16'hBBBB, 16'h0, 16'h0};
    issue_start(1'b0, 8'h05, 16'h0010);
    mem_ack = 1'b1;
    for (int c = 0; c < 6; c++) begin
      mem_rdata = (c == 0) ? 16'hAAAA : (c == 2) ? 16'hBBBB : 16'h5555;
      checks++;
      if ({mem_en, rf_we, done, busy} !== {e_en[c], e_we[c], e_dn[c], e_bs[c]}) begin
        errors++; $display("FAIL lm_ctrl cyc %0d got %b exp %b", c + 1,
          {mem_en, rf_we, done, busy}, {e_en[c], e_we[c], e_dn[c], e_bs[c]});
      end
      if (e_en[c]) begin
        checks++;
        if ({mem_addr, read_wbar, rf_addr} !== {e_ad[c], 1'b1, e_ra[c]}) begin
          errors++; $display("FAIL lm_access cyc %0d got %h/%b/%0d exp %h/1/%0d", c + 1,
            mem_addr, read_wbar, rf_addr, e_ad[c], e_ra[c]);
        end
      end
      if (e_we[c]) begin
        checks++;
        if ({rf_addr, rf_wdata} !== {e_ra[c], e_wd[c]}) begin
          errors++; $display("FAIL lm_wb cyc %0d got R%0d=%h exp R%0d=%h", c + 1,
            rf_addr, rf_wdata, e_ra[c], e_wd[c]);
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_sm_wrap();
    logic        e_ack [7] = '{0, 0, 1, 0, 0, 1, 0};
    logic [15:0] e_ad  [7] = '{16'hFFFF, 16'hFFFF, 16'hFFFF, 16'h0000, 16'h0000, 16'h0000, 16'h0};
    logic [2:0]  e_ra  [7] = '{3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd0};
    issue_start(1'b1, 8'h81, 16'hFFFF);
    for (int c = 0; c < 7; c++) begin
      mem_ack = e_ack[c];
      checks++;
      if ({mem_en, rf_we, done} !== {(c < 6), 1'b0, (c == 6)}) begin
        errors++; $display("FAIL sm_ctrl cyc %0d got %b exp %b", c + 1,
          {mem_en, rf_we, done}, {(c < 6), 1'b0, (c == 6)});
      end
      if (c < 6) begin
        checks++;
        if ({mem_addr, read_wbar, rf_addr} !== {e_ad[c], 1'b0, e_ra[c]}) begin
          errors++; $display("FAIL sm_access cyc %0d got %h/%b/%0d exp %h/0/%0d", c + 1,
            mem_addr, read_wbar, rf_addr, e_ad[c], e_ra[c]);
        end
      end
      @(negedge clk);
    end
    mem_ack = 1'b0;
  endtask

  task automatic test_zero_mask();
    issue_start(1'b0, 8'h00, 16'h1234);
    checks++;
    if ({done, busy, mem_en} !== 3'b110) begin
      errors++; $display("FAIL zero_done got %b exp 110", {done, busy, mem_en});
    end
`ifdef LMSM_BASE_WRITEBACK_EN
    checks++;
    if ({base_we, base_next} !== {1'b1, 16'h1234}) begin
      errors++; $display("FAIL zero_base got %b/%h exp 1/1234", base_we, base_next);
    end
`endif
    @(negedge clk);
    checks++;
    if ({done, busy, mem_en} !== 3'b000) begin
      errors++; $display("FAIL zero_idle got %b exp 000", {done, busy, mem_en});
    end
  endtask

  task automatic test_start_while_busy();
    int n_acc = 0;
    int n_done = 0;
    logic [15:0] e_ad;
    issue_start(1'b0, 8'h03, 16'h0040);
    mem_ack = 1'b1;
    mem_rdata = 16'h1111;
    for (int c = 1; c <= 8; c++) begin
      // extra starts during the burst and on the done cycle must be dropped
      start = (c == 2 || c == 5);
      is_store = 1'b1; reg_mask = 8'hFF; base_addr = 16'h0100;
      if (mem_en) begin
        e_ad = 16'h0040 + 16'(n_acc);
        checks++;
        if (mem_addr !== e_ad) begin
          errors++; $display("FAIL busy_addr cyc %0d got %h exp %h", c, mem_addr, e_ad);
        end
        n_acc++;
      end
      if (done) n_done++;
      @(negedge clk);
    end
    start = 1'b0;
    checks++;
    if (n_acc !== 2) begin errors++; $display("FAIL busy_accesses got %0d exp 2", n_acc); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL busy_dones got %0d exp 1", n_done); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL busy_back_idle got %b exp 0", busy); end
    issue_start(1'b1, 8'h01, 16'h0200);
    checks++;
    if ({mem_en, read_wbar, mem_addr, rf_addr} !== {1'b1, 1'b0, 16'h0200, 3'd0}) begin
      errors++; $display("FAIL busy_restart got %b/%b/%h/%0d exp 1/0/0200/0",
        mem_en, read_wbar, mem_addr, rf_addr);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1) begin errors++; $display("FAIL busy_restart_done got %b exp 1", done); end
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int n_done = 0;
    issue_start(1'b0, 8'hFF, 16'h0000);
    mem_ack = 1'b1;
    repeat (4) @(negedge clk);
    checks++;
    if ({mem_en, mem_addr, rf_addr} !== {1'b1, 16'h0002, 3'd2}) begin
      errors++; $display("FAIL rmid_third got %b/%h/%0d exp 1/0002/2", mem_en, mem_addr, rf_addr);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({busy, done, mem_en, rf_we, read_wbar, mem_addr, rf_addr, rf_wdata} !== {5'b00001, 35'h0}) begin
      errors++; $display("FAIL rmid_async got %b %h %0d %h exp 00001 0 0 0",
        {busy, done, mem_en, rf_we, read_wbar}, mem_addr, rf_addr, rf_wdata);
    end
    @(negedge clk);
    reset = 1'b0;
    mem_ack = 1'b0;
    for (int c = 0; c < 4; c++) begin
      if (done) n_done++;
      checks++;
      if ({busy, mem_en} !== 2'b00) begin
        errors++; $display("FAIL rmid_idle cyc %0d got %b exp 00", c, {busy, mem_en});
      end
      @(negedge clk);
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL rmid_no_done got %0d exp 0", n_done); end
  endtask

  task automatic test_sm_burst();
    logic [15:0] e_ad;
    logic [2:0]  e_ra;
    issue_start(1'b1, 8'hF0, 16'h1000);
    mem_ack = 1'b1;
    for (int c = 0; c < 4; c++) begin
      e_ad = 16'h1000 + 16'(c);
      e_ra = 3'(c + 4);
      checks++;
      if ({mem_en, done, mem_addr, rf_addr} !== {2'b10, e_ad, e_ra}) begin
        errors++; $display("FAIL burst_access cyc %0d got %b/%b/%h/%0d exp 1/0/%h/%0d", c + 1,
          mem_en, done, mem_addr, rf_addr, e_ad, e_ra);
      end
`ifdef LMSM_BASE_WRITEBACK_EN
      checks++;
      if (base_we !== 1'b0) begin errors++; $display("FAIL burst_base_early got %b exp 0", base_we); end
`endif
      @(negedge clk);
    end
    checks++;
    if ({mem_en, done} !== 2'b01) begin
      errors++; $display("FAIL burst_done got %b exp 01", {mem_en, done});
    end
`ifdef LMSM_BASE_WRITEBACK_EN
    checks++;
    if ({base_we, base_next} !== {1'b1, 16'h1004}) begin
      errors++; $display("FAIL burst_base got %b/%h exp 1/1004", base_we, base_next);
    end
`endif
    mem_ack = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; is_store = 1'b0; reg_mask = 8'h00;
    base_addr = 16'h0; mem_ack = 1'b0; mem_rdata = 16'h0;
    test_reset();
    test_lm_basic();
    test_sm_wrap();
    test_zero_mask();
    test_start_while_busy();
    test_reset_mid();
    test_sm_burst();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lm_sm_sequencer.md
Name: lm_sm_sequencer

Overview:
Sequences the multiple-register load/store instructions (LM/SM) for the multicycle datapath. The controller hands it an 8-bit register mask, a base address and a direction. The block then walks the mask from lowest to highest register and issues one memory access per set bit at consecutive addresses. For loads it also drives the register-file write. It sits between the controller and the memory/register-file ports and owns them while busy.

Parameters:
NREGS, 8, number of architectural registers = width of reg_mask
ADDR_W, 16, memory address width
DATA_W, 16, memory/register data width
RIDX_W, 3, register index width (log2 NREGS)

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to begin an LM/SM; ignored unless idle
is_store  input  1  1 = SM (RF->mem), 0 = LM (mem->RF); sampled with start
reg_mask  input  NREGS  bit i set = transfer register Ri; sampled with start
base_addr  input  ADDR_W  first memory address; sampled with start
mem_ack  input  1  memory completed current access
mem_rdata  input  DATA_W  read data, valid with mem_ack
busy  output  1  sequencer owns memory/RF ports
done  output  1  one-cycle completion pulse
mem_en  output  1  memory request, held until mem_ack
read_wbar  output  1  1 = read, 0 = write
mem_addr  output  ADDR_W  current access address
rf_addr  output  RIDX_W  register index for current transfer (RF read port for SM, write port for LM)
rf_we  output  1  register-file write strobe (LM only)
rf_wdata  output  DATA_W  latched load data

Behaviour:
- Reset (async, any state): state=IDLE. busy, done, mem_en, rf_we = 0. read_wbar=1. mem_addr, rf_addr, rf_wdata = 0. Internal mask/address/direction registers cleared.
- States: IDLE, ACCESS, WB, DONE.
- IDLE: start=1 latches reg_mask->rem_mask, base_addr->cur_addr, is_store->dir.
  - rem_mask nonzero -> ACCESS next cycle.
  - rem_mask zero -> DONE next cycle (no memory traffic).
- busy=1 in ACCESS, WB and DONE.
- ACCESS:
  - mem_en=1, mem_addr=cur_addr, read_wbar=~dir.
  - rf_addr = index of lowest set bit of rem_mask (priority encoder, R0 highest priority).
  - Outputs held stable until mem_ack.
  - On mem_ack: clear that bit of rem_mask; cur_addr <= cur_addr+1, modulo 2^ADDR_W (0xFFFF wraps to 0x0000).
  - On mem_ack for a load: latch mem_rdata->rf_wdata and rf_idx; go to WB.
  - On mem_ack for a store: go to ACCESS if the remaining mask is nonzero, else DONE.
  - Back-to-back stores with immediate ack therefore take 1 cycle each.
- WB: rf_we=1 for exactly one cycle, rf_addr=latched index, rf_wdata valid; mem_en=0. Next state is ACCESS if rem_mask is nonzero, else DONE.
- DONE: done=1 for one cycle, mem_en=0, rf_we=0; next state IDLE.
- Addresses are consecutive per set bit, independent of gaps in the mask (mask 0b1001 uses base and base+1).
- start while not IDLE is ignored, with no latching or queuing.
- start in the same cycle done is high is ignored; accepted from the following IDLE cycle.
- mem_ack outside ACCESS is ignored.
- mem_ack held high through consecutive cycles counts once per ACCESS cycle.
- Reset asserted mid-transfer aborts immediately. No done pulse; partially written registers are not rolled back.
- Latency, from the start edge, for n set bits with zero-wait ack:
  - LM: 2n+1 cycles to the done pulse.
  - SM: n+1 cycles to the done pulse.

Optional Feature:
Macro LMSM_BASE_WRITEBACK_EN.
- Defined: extra outputs base_we (1) and base_next (ADDR_W).
  - In DONE, base_we=1 for one cycle and base_next = base_addr + popcount(reg_mask), modulo 2^ADDR_W.
  - Reset value of both is 0.
  - Zero mask gives base_next = base_addr.
- Undefined: ports and popcount logic are absent; base register is never updated.

Test Plan:
- Reset mid-LM (mask 0xFF, during 3rd ACCESS) -> all outputs 0 / read_wbar=1 within the same cycle; IDLE after release; no done pulse.
- LM, mask 0x05, base 0x0010, ack same cycle, mem_rdata 0xAAAA then 0xBBBB:
  - reads at 0x0010 (rf_addr 0) then 0x0011 (rf_addr 2);
  - rf_we pulses write R0=0xAAAA, then R2=0xBBBB;
  - done at cycle 5.
- SM, mask 0x81, base 0xFFFF, ack delayed 2 cycles per access:
  - writes at 0xFFFF (rf_addr 0) then 0x0000 (rf_addr 7), address wraps;
  - mem_en/mem_addr held stable while waiting; rf_we never asserted.
- Mask 0x00 start -> done one cycle after start; mem_en never asserted; with LMSM_BASE_WRITEBACK_EN, base_next = base_addr.
- Second start pulse while busy (during LM of mask 0x03) -> ignored; exactly two accesses, one done; new start accepted after return to IDLE.
- With LMSM_BASE_WRITEBACK_EN, SM mask 0xF0, base 0x1000 -> base_we pulse in DONE with base_next=0x1004.
